// File: rtl/sq_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sq_mac_seq                                                  |
// | Purpose : Sequential a*a + b*c with a shared shift-add multiplier,    |
// |           serial double-dabble BCD conversion and an active-low       |
// |           seven-segment driver with leading-zero blanking/overflow.   |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sq_mac_seq #(
  parameter int W    = 4,
  parameter int NDIG = 3,
  parameter int LZB  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  input  logic [W-1:0]        c,
  output logic                busy,
  output logic                done,
  output logic [2*W:0]        result,
  output logic                ovf,
  output logic [4*NDIG-1:0]   bcd,
  output logic [8*NDIG-1:0]   hex
);

  localparam int RW = 2 * W + 1;
  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_A = 3'd1,
    S_MUL_B = 3'd2,
    S_ADD   = 3'd3,
    S_BCD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    b_q, c_q;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [2*W-1:0]  p1, p2;
  logic [RW-1:0]   sum_q, sum_sr;
  logic [BW-1:0]   dig;
  logic            ovf_i;
  logic [CW-1:0]   cnt;

  logic [2*W-1:0]  pp_sum;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   dig_nx;
  logic            ovf_nx;
  logic [8*NDIG-1:0] hex_nx;

  logic            mul_last;
  logic            bcd_last;

  assign mul_last = (cnt == CW'(W - 1));
  assign bcd_last = (cnt == CW'(RW - 1));

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Single adder shared by both products: accumulate into p1 during MUL_A, p2 during MUL_B
  always_comb begin
    pp_sum = ((state == S_MUL_A) ? p1 : p2) + mcand;
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift in the next sum bit;
  // a 1 leaving the top nibble means the value needs more than NDIG digits
  always_comb begin
    adj = dig;
    for (int k = 0; k < NDIG; k++) begin
      if (dig[4*k +: 4] > 4'd4) adj[4*k +: 4] = dig[4*k +: 4] + 4'd3;
    end
    dig_nx = {adj[BW-2:0], sum_sr[RW-1]};
    ovf_nx = ovf_i | adj[BW-1];
  end

  // Segment codes for the value about to be published, with blanking and dash-on-overflow
  always_comb begin
    logic       seen;
    logic [3:0] dg;
    hex_nx = '0;
    seen   = 1'b0;
    dg     = 4'd0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      dg = dig_nx[4*k +: 4];
      if (dg != 4'd0) seen = 1'b1;
      if (ovf_nx)
        hex_nx[8*k +: 8] = 8'hBF;
      else if ((LZB != 0) && (k != 0) && !seen)
        hex_nx[8*k +: 8] = 8'hFF;
      else
        hex_nx[8*k +: 8] = seg7(dg);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state sequencing: fixed-length phases counted by cnt
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)    state_nx = S_MUL_A;
      S_MUL_A: if (mul_last) state_nx = S_MUL_B;
      S_MUL_B: if (mul_last) state_nx = S_ADD;
      S_ADD:                 state_nx = S_BCD;
      S_BCD:   if (bcd_last) state_nx = S_DONE;
      S_DONE:                state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; outputs only change on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      c_q    <= '0;
      mcand  <= '0;
      mplier <= '0;
      p1     <= '0;
      p2     <= '0;
      sum_q  <= '0;
      sum_sr <= '0;
      dig    <= '0;
      ovf_i  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      bcd    <= '0;
      for (int k = 0; k < NDIG; k++) begin
        hex[8*k +: 8] <= ((k == 0) || (LZB == 0)) ? 8'hC0 : 8'hFF;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            b_q    <= b;
            c_q    <= c;
            mcand  <= {{W{1'b0}}, a};
            mplier <= a;
            p1     <= '0;
            p2     <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        S_MUL_A: begin
          if (mplier[0]) p1 <= pp_sum;
          if (mul_last) begin
            mcand  <= {{W{1'b0}}, b_q};
            mplier <= c_q;
            cnt    <= '0;
          end else begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        S_MUL_B: begin
          if (mplier[0]) p2 <= pp_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= mul_last ? '0 : cnt + 1'b1;
        end
        S_ADD: begin
          sum_q  <= {1'b0, p1} + {1'b0, p2};
          sum_sr <= {1'b0, p1} + {1'b0, p2};
          dig    <= '0;
          ovf_i  <= 1'b0;
          cnt    <= '0;
        end
        S_BCD: begin
          dig    <= dig_nx;
          ovf_i  <= ovf_nx;
          sum_sr <= sum_sr << 1;
          cnt    <= cnt + 1'b1;
          if (bcd_last) begin
            result <= sum_q;
            bcd    <= dig_nx;
            ovf    <= ovf_nx;
            hex    <= hex_nx;
            done   <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sq_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sq_mac_seq                                               |
// | Purpose : Scoreboard bench for sq_mac_seq over four parameter sets:   |
// |           0: W4/N3/LZB1  1: W4/N3/LZB0  2: W4/N2/LZB1  3: W3/N2/LZB1  |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_sq_mac_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [3:0] a_in, b_in, c_in;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  r0, r1, r2;
  logic [6:0]  r3;
  logic [11:0] bc0, bc1;
  logic [7:0]  bc2, bc3;
  logic [23:0] hx0, hx1;
  logic [15:0] hx2, hx3;
  logic        d0, d1, d2, d3, bz0, bz1, bz2, bz3, o0, o1, o2, o3;

  sq_mac_seq #(.W(4), .NDIG(3), .LZB(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_in), .b(b_in), .c(c_in), .busy(bz0), .done(d0), .result(r0), .ovf(o0), .bcd(bc0), .hex(hx0));
  sq_mac_seq #(.W(4), .NDIG(3), .LZB(0)) u1 (.clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_in), .b(b_in), .c(c_in), .busy(bz1), .done(d1), .result(r1), .ovf(o1), .bcd(bc1), .hex(hx1));
  sq_mac_seq #(.W(4), .NDIG(2), .LZB(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .a(a_in), .b(b_in), .c(c_in), .busy(bz2), .done(d2), .result(r2), .ovf(o2), .bcd(bc2), .hex(hx2));
  sq_mac_seq #(.W(3), .NDIG(2), .LZB(1)) u3 (.clk(clk), .rst_n(rst_n), .start(start_v[3]),
    .a(a_in[2:0]), .b(b_in[2:0]), .c(c_in[2:0]), .busy(bz3), .done(d3), .result(r3), .ovf(o3), .bcd(bc3), .hex(hx3));

  wire [31:0] res_v [4];
  wire [31:0] bcd_v [4];
  wire [31:0] hex_v [4];
  wire [3:0]  done_v = {d3, d2, d1, d0};
  wire [3:0]  busy_v = {bz3, bz2, bz1, bz0};
  wire [3:0]  ovf_v  = {o3, o2, o1, o0};
  assign res_v[0] = 32'(r0);  assign res_v[1] = 32'(r1);  assign res_v[2] = 32'(r2);  assign res_v[3] = 32'(r3);
  assign bcd_v[0] = 32'(bc0); assign bcd_v[1] = 32'(bc1); assign bcd_v[2] = 32'(bc2); assign bcd_v[3] = 32'(bc3);
  assign hex_v[0] = 32'(hx0); assign hex_v[1] = 32'(hx1); assign hex_v[2] = 32'(hx2); assign hex_v[3] = 32'(hx3);

  typedef struct {
    int          inst;
    logic [31:0] res;
    logic [31:0] bcd;
    logic [31:0] hex;
    logic        ovf;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // Reference model: arithmetic by multiply, digits by division
  function automatic exp_t model(input int k, input int a, input int b, input int c);
    exp_t e;
    int   w   = (k == 3) ? 3 : 4;
    int   n   = (k >= 2) ? 2 : 3;
    bit   lzb = (k != 1);
    int   m   = (1 << w) - 1;
    int   v, p, lim;
    v = (a & m) * (a & m) + (b & m) * (c & m);
    lim = 1;
    for (int i = 0; i < n; i++) lim = lim * 10;
    e.inst = k;
    e.res  = 32'(v);
    e.ovf  = (v >= lim);
    e.bcd  = '0;
    e.hex  = '0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      e.bcd[4*i +: 4] = 4'((v / p) % 10);
      if (e.ovf)                       e.hex[8*i +: 8] = 8'hBF;
      else if (i > 0 && lzb && v < p)  e.hex[8*i +: 8] = 8'hFF;
      else                             e.hex[8*i +: 8] = seg_of((v / p) % 10);
      p = p * 10;
    end
    e.t0  = 0;
    e.lat = 2 * w + 2 + (2 * w + 1);
    return e;
  endfunction

  // Pop and compare whenever any instance pulses done
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 32'(done_v[k]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("done_inst", k, e.inst);
          check_val("done_cycle", cyc - e.t0, e.lat);
          check_val("result", res_v[k], e.res);
          check_val("bcd", bcd_v[k], e.bcd);
          check_val("hex", hex_v[k], e.hex);
          check_val("ovf", 32'(ovf_v[k]), 32'(e.ovf));
          check_val("busy_at_done", 32'(busy_v[k]), 32'd1);
        end
      end
    end
  end

  task automatic launch(input int k, input int a, input int b, input int c);
    exp_t e;
    @(negedge clk);
    a_in = 4'(a); b_in = 4'(b); c_in = 4'(c);
    start_v[k] = 1'b1;
    e = model(k, a, b, c);
    e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    check_val("drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset(input int k, input string tag);
    exp_t z;
    z = model(k, 0, 0, 0);
    check_val({tag, "_busy"}, 32'(busy_v[k]), 32'd0);
    check_val({tag, "_done"}, 32'(done_v[k]), 32'd0);
    check_val({tag, "_result"}, res_v[k], 32'd0);
    check_val({tag, "_bcd"}, bcd_v[k], 32'd0);
    check_val({tag, "_ovf"}, 32'(ovf_v[k]), 32'd0);
    check_val({tag, "_hex"}, hex_v[k], z.hex);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; start_v = '0; a_in = '0; b_in = '0; c_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) check_reset(k, "por");

    // basic operation, blanking and the all-max case
    launch(0, 3, 2, 5);
    check_val("busy_cycle1", 32'(bz0), 32'd1);
    drain();
    launch(0, 15, 15, 15); drain();
    launch(0, 0, 0, 0);    drain();
    launch(1, 1, 0, 0);    drain();

    // start while busy is ignored; operand changes after acceptance have no effect
    launch(0, 2, 3, 3);
    repeat (4) @(negedge clk);
    a_in = 4'd15; start_v[0] = 1'b1;
    check_val("busy_ignored_start", 32'(bz0), 32'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 4'd9;
    drain();
    repeat (25) @(negedge clk);
    check_val("idle_after_single", 32'(bz0), 32'd0);

    // start held high: back-to-back operations, next accepted in the IDLE cycle after DONE
    @(negedge clk);
    a_in = 4'd7; b_in = 4'd9; c_in = 4'd11; start_v[0] = 1'b1;
    e = model(0, 7, 9, 11); e.t0 = cyc;      sb.push_back(e);
    e = model(0, 7, 9, 11); e.t0 = cyc + 20; sb.push_back(e);
    for (int i = 0; i < 40 && sb.size() > 1; i++) begin
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    start_v[0] = 1'b0;
    drain();

    // reset in the middle of an operation discards it
    launch(0, 5, 6, 7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset(0, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_reset(0, "postrst");
    launch(0, 3, 2, 5); drain();

    // overflow and the narrow-operand configuration
    launch(2, 15, 15, 15); drain();
    launch(3, 7, 7, 7);    drain();

    // random operands
    for (int i = 0; i < 4; i++) begin
      launch(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      launch(2, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      drain();
      launch(3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      drain();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
